// File: rtl/overlap_framing.sv
// Overlapping framer: buffers the sample stream in a ring buffer and replays
// FRAME_LEN-sample windows every HOP_LEN samples with output backpressure and cadence.
module overlap_framing #(
    parameter int unsigned I_BW        = 9,
    parameter int unsigned O_BW        = 16,
    parameter int unsigned FRAME_LEN   = 256,
    parameter int unsigned HOP_LEN     = 128,
    parameter int unsigned CADENCE_CYC = 3,
    parameter int unsigned BUF_DEPTH   = 512
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [I_BW-1:0] data_i,
    input  logic            valid_i,
    output logic [O_BW-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            last_o,
    output logic            overflow_o,
    output logic [15:0]     frame_cnt_o
);

    localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned IDX_W  = $clog2(FRAME_LEN);
    localparam int unsigned HOLD_W = (CADENCE_CYC > 1) ? $clog2(CADENCE_CYC) : 1;

    typedef enum logic {
        LOAD   = 1'b0,
        UNLOAD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [I_BW-1:0]     mem [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    base_q;
    logic [FILL_W-1:0]   fill_q;
    logic [IDX_W-1:0]    idx_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                overflow_q;
    logic [15:0]         frame_cnt_q;

    logic                clear_c;
    logic                full_c;
    logic                wr_c;
    logic                drop_c;
    logic                acc_c;
    logic                idx_last_c;
    logic                frame_end_c;
    logic [PTR_W-1:0]    rd_addr_c;
    logic signed [I_BW-1:0] rd_s_c;

    assign clear_c     = rst_i | ~en_i;
    assign full_c      = (fill_q >= FILL_W'(BUF_DEPTH));
    assign wr_c        = ~rst_i & en_i & valid_i & ~full_c;
    assign drop_c      = ~rst_i & en_i & valid_i & full_c;
    assign valid_o     = (state_q == UNLOAD);
    assign acc_c       = valid_o & ready_i & (hold_q >= HOLD_W'(CADENCE_CYC - 1));
    assign idx_last_c  = (idx_q == IDX_W'(FRAME_LEN - 1));
    assign frame_end_c = acc_c & idx_last_c;

    // Combinational read of the active element from registered pointers
    assign rd_addr_c   = base_q + PTR_W'(idx_q);
    assign rd_s_c      = mem[rd_addr_c];
    assign data_o      = O_BW'(rd_s_c);
    assign last_o      = valid_o & idx_last_c;
    assign overflow_o  = overflow_q;
    assign frame_cnt_o = frame_cnt_q;

    always_ff @(posedge clk_i) begin
        if (clear_c) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (fill_q >= FILL_W'(FRAME_LEN)) begin
                    state_d = UNLOAD;
                end
            end
            UNLOAD: begin
                if (frame_end_c) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Sample storage; contents survive reset, only pointers are cleared
    always_ff @(posedge clk_i) begin
        if (wr_c) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_c) begin
            wr_ptr_q    <= '0;
            base_q      <= '0;
            fill_q      <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (wr_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            // A write and a frame retire in the same cycle are both applied
            fill_q <= fill_q + FILL_W'(wr_c) - (frame_end_c ? FILL_W'(HOP_LEN) : FILL_W'(0));
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
            if (frame_end_c) begin
                base_q      <= base_q + PTR_W'(HOP_LEN);
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (state_q == LOAD) begin
                idx_q <= '0;
            end else if (acc_c) begin
                idx_q <= idx_last_c ? IDX_W'(0) : idx_q + IDX_W'(1);
            end
            if ((state_q == LOAD) || acc_c) begin
                hold_q <= '0;
            end else if (hold_q < HOLD_W'(CADENCE_CYC - 1)) begin
                hold_q <= hold_q + HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_overlap_framing.sv
// Self-checking bench for overlap_framing: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based stream model.
module tb_overlap_framing;

    localparam int FL = 8;
    localparam int HL = 4;
    localparam int CD = 2;
    localparam int BD = 16;

    logic        clk_i;
    logic        rst_i;
    logic        en_i;
    logic [8:0]  data_i;
    logic        valid_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        overflow_o;
    logic [15:0] frame_cnt_o;

    overlap_framing #(
        .I_BW(9), .O_BW(16), .FRAME_LEN(FL), .HOP_LEN(HL),
        .CADENCE_CYC(CD), .BUF_DEPTH(BD)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i),
        .valid_i(valid_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .last_o(last_o), .overflow_o(overflow_o),
        .frame_cnt_o(frame_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Stream model: every stored sample since the last clear, in arrival order.
    // Frame k is samples [k*HL, k*HL+FL) of that stream.
    logic [8:0] mq[$];
    int  mk   = 0;
    int  me   = 0;
    int  mcnt = 0;
    bit  mpres = 1'b0;
    bit  movf  = 1'b0;

    function automatic logic [15:0] sext(input logic [8:0] s);
        return {{7{s[8]}}, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic check_outputs();
        chk("valid_o", 32'(valid_o), 32'(mpres));
        chk("overflow_o", 32'(overflow_o), 32'(movf));
        chk("frame_cnt_o", 32'(frame_cnt_o), 32'(mk[15:0]));
        if (mpres) begin
            chk("data_o", 32'(data_o), 32'(sext(mq[mk*HL + me])));
            chk("last_o", 32'(last_o), 32'(me == FL - 1));
        end else begin
            chk("last_o_idle", 32'(last_o), 32'(0));
        end
    endtask

    // Advance the model across one clock edge with the given inputs
    task automatic model_step(input bit r, input bit en, input bit v,
                              input logic [8:0] d, input bit rdy);
        int fill;
        if (r || !en) begin
            mq.delete();
            mk = 0; me = 0; mcnt = 0; mpres = 1'b0; movf = 1'b0;
            return;
        end
        fill = mq.size() - mk*HL;
        if (mpres) begin
            if (rdy && mcnt >= CD) begin
                me++;
                mcnt = 1;
                if (me == FL) begin
                    me = 0;
                    mk++;
                    mpres = 1'b0;
                end
            end else begin
                mcnt++;
            end
        end else if (fill >= FL) begin
            mpres = 1'b1;
            me = 0;
            mcnt = 1;
        end
        if (v) begin
            if (fill < BD) mq.push_back(d);
            else movf = 1'b1;
        end
    endtask

    task automatic cycle(input bit r, input bit en, input bit v,
                         input logic [8:0] d, input bit rdy);
        rst_i = r; en_i = en; valid_i = v; data_i = d; ready_i = rdy;
        check_outputs();
        model_step(r, en, v, d, rdy);
        @(posedge clk_i);
        #1;
    endtask

    task automatic feed(input int start, input int n, input int gap, input bit rdy);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 9'(start + i), rdy);
            repeat (gap) cycle(1'b0, 1'b1, 1'b0, 9'd0, rdy);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cycle(1'b0, 1'b1, 1'b0, 9'd0, rdy);
    endtask

    task automatic wait_elem(input int target);
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mpres && me == target) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 1'b1, 1'b0, 9'd0, 1'b1);
        end
        chk("wait_elem", 32'(found), 32'(1));
    endtask

    task automatic wait_frames(input int target);
        bit found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (mk >= target && !mpres) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 1'b1, 1'b0, 9'd0, 1'b1);
        end
        chk("wait_frames", 32'(found), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; en_i = 1'b1; valid_i = 1'b1; data_i = 9'h0AA; ready_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset with valid_i high: everything zero, nothing stored
        cycle(1'b1, 1'b1, 1'b1, 9'h055, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 9'h033, 1'b1);
        chk("reset_valid", 32'(valid_o), 32'(0));
        chk("reset_cnt", 32'(frame_cnt_o), 32'(0));

        // First frame 0..7, then second frame 4..11
        feed(0, 8, 2, 1'b1);
        idle(20, 1'b1);
        chk("frame_cnt_1", 32'(frame_cnt_o), 32'(1));
        feed(8, 4, 2, 1'b1);
        idle(20, 1'b1);
        chk("frame_cnt_2", 32'(frame_cnt_o), 32'(2));

        // Backpressure while element 3 is presented
        cycle(1'b1, 1'b1, 1'b0, 9'd0, 1'b1);
        feed(0, 8, 0, 1'b1);
        wait_elem(3);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 9'd0, 1'b0);
            chk("bp_hold", 32'(data_o), 32'(16'd3));
        end
        wait_frames(1);

        // Overflow: 20 samples with no drain, 16..19 dropped
        cycle(1'b1, 1'b1, 1'b0, 9'd0, 1'b1);
        feed(0, 20, 0, 1'b0);
        chk("overflow_set", 32'(overflow_o), 32'(1));
        wait_frames(3);
        chk("overflow_sticky", 32'(overflow_o), 32'(1));
        chk("overflow_frames", 32'(frame_cnt_o), 32'(3));

        // Sign extension of the most negative input
        cycle(1'b1, 1'b1, 1'b0, 9'd0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 9'h100, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b1, 9'($urandom), 1'b1);
        wait_elem(0);
        chk("sext", 32'(data_o), 32'(16'hFF00));
        wait_frames(1);

        // en_i low mid-frame abandons it; a fresh window is required
        cycle(1'b1, 1'b1, 1'b0, 9'd0, 1'b1);
        feed(0, 8, 0, 1'b1);
        wait_elem(2);
        cycle(1'b0, 1'b0, 1'b1, 9'd0, 1'b1);
        chk("en_clear_valid", 32'(valid_o), 32'(0));
        chk("en_clear_cnt", 32'(frame_cnt_o), 32'(0));
        feed(0, 8, 2, 1'b1);
        wait_frames(1);

        // Random traffic against the model
        cycle(1'b1, 1'b1, 1'b0, 9'd0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            cycle(1'b0, ($urandom_range(0, 149) != 0), ($urandom_range(0, 1) == 0),
                  9'($urandom), ($urandom_range(0, 9) < 7));
        end
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/overlap_framing.md
# overlap_framing

Parametrised successor to the non-overlapping framer. It buffers the preemphasis sample stream in a ring buffer and emits frames of FRAME_LEN samples with a hop of HOP_LEN, so consecutive frames overlap by FRAME_LEN − HOP_LEN samples. It sits between preemphasis and FFT. It adds the following over the previous framer:
- output backpressure (`ready_i`);
- a minimum per-element hold (CADENCE_CYC);
- sign extension to O_BW;
- sticky overflow reporting;
- a completed-frame counter.

## Interface
- `I_BW`, 9: input sample width, signed.
- `O_BW`, 16: output width, signed; must be ≥ I_BW.
- `FRAME_LEN`, 256: samples per frame; must be ≥ 2.
- `HOP_LEN`, 128: samples between frame starts; 1 ≤ HOP_LEN ≤ FRAME_LEN.
- `CADENCE_CYC`, 3: minimum cycles each output element is presented; must be ≥ 1.
- `BUF_DEPTH`, 512: ring-buffer entries; power of two, ≥ FRAME_LEN + HOP_LEN.

Ports:
- `clk_i` in 1: clock. The block uses one clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `en_i` in 1: enable. Low acts as a synchronous clear, identical to reset.
- `data_i` in I_BW: input sample, signed.
- `valid_i` in 1: `data_i` is valid this cycle. There is no input backpressure.
- `data_o` out O_BW: current frame element, sign-extended.
- `valid_o` out 1: `data_o` holds a frame element.
- `ready_i` in 1: downstream can accept.
- `last_o` out 1: the presented element is element FRAME_LEN−1.
- `overflow_o` out 1: sticky; at least one sample has been dropped.
- `frame_cnt_o` out 16: completed frames, wraps at 2^16.

## Operation

Storage and pointers:
- `mem[BUF_DEPTH]` holds I_BW-wide samples.
- `wr_ptr` and `base` are each log2(BUF_DEPTH) bits and wrap naturally.
- `fill` is log2(BUF_DEPTH)+1 bits and counts stored samples from `base`.
- `idx` is log2(FRAME_LEN) bits and is the element index within the frame.
- `hold` is the cadence counter.

Write path:
- `wr = en_i & valid_i & (fill < BUF_DEPTH)`.
- On `wr`: `mem[wr_ptr] <= data_i` and `wr_ptr` increments.
- If `valid_i` arrives while `fill == BUF_DEPTH`, the sample is dropped and `overflow_o` is set. `overflow_o` clears only on reset or `en_i` low.
- Writes never hit the active window, because `wr_ptr == base + fill`.

Read path:
- `data_o = sign-extend(mem[base + idx])`. This is a combinational read from registered pointers.
- `data_o` is don't-care while `valid_o` is 0.

Element acceptance:
- `acc = valid_o & ready_i & (hold >= CADENCE_CYC − 1)`.
- `hold` resets to 0 on `acc` and on frame start.
- Otherwise `hold` increments while in UNLOAD, saturating at CADENCE_CYC−1.

FSM:
- LOAD: `valid_o` = 0, `idx` = 0, `hold` = 0. Go to UNLOAD when `fill ≥ FRAME_LEN`.
- UNLOAD: `valid_o` = 1.
  - On `acc` with `idx < FRAME_LEN−1`: increment `idx`.
  - On `acc` with `idx == FRAME_LEN−1`: set `base += HOP_LEN`, increment `frame_cnt_o`, set `idx` to 0, and go to LOAD.

Fill update (same cycle):
- `fill_next = fill + wr − (frame end ? HOP_LEN : 0)`.
- A write and a frame retire in the same cycle are both applied.

Outputs:
- `last_o = valid_o & (idx == FRAME_LEN−1)`.

Reset or `en_i` low:
- All of `wr_ptr`, `base`, `fill`, `idx`, `hold`, state, `overflow_o` and `frame_cnt_o` go to 0. State goes to LOAD.
- Memory contents are not cleared.
- Reset mid-frame abandons the frame: `valid_o` is 0 from the next cycle.

## Timing
- All outputs reset to 0: `valid_o`, `last_o`, `overflow_o`, `frame_cnt_o`; `data_o` is don't-care.
- Frame start latency: `valid_o` rises one cycle after the edge that captures the FRAME_LEN-th sample of a window.
- Element pacing: each element is presented for at least CADENCE_CYC cycles. With `ready_i` held high, exactly CADENCE_CYC cycles.
- Backpressure: `data_o`, `last_o` and `idx` stay stable while `ready_i` is low. Elements are never skipped or duplicated.
- Inter-frame gap: exactly one LOAD cycle (`valid_o` = 0) between frames, even when the next window is already buffered.
- Frame counter: `frame_cnt_o` updates on the edge after the last element's `acc`.

## Test plan
Configuration for all cases unless noted: FRAME_LEN=8, HOP_LEN=4, CADENCE_CYC=2, BUF_DEPTH=16.

1. Assert `rst_i` for 2 cycles with `valid_i` = 1 -> `valid_o`, `last_o`, `overflow_o` and `frame_cnt_o` are all 0, and nothing is stored.
2. With `ready_i` = 1, feed samples 0..7, one every 3 cycles -> `valid_o` rises the cycle after capturing sample 7. `data_o` is 0..7, each for 2 cycles. `last_o` is high only with 7. `frame_cnt_o` = 1.
3. Continue with samples 8..11 -> second frame is 4..11 after the one-cycle LOAD gap. `frame_cnt_o` = 2.
4. Drop `ready_i` for 5 cycles while element 3 is presented -> `data_o` stays 3. On release the sequence resumes 4..7 with no skips or duplicates.
5. Hold `ready_i` = 0 and feed 20 samples 0..19 -> 16 are stored, 16..19 are dropped, and `overflow_o` = 1 and stays high. Releasing `ready_i` yields frames 0..7, 4..11 and 8..15, and `overflow_o` stays high.
6. Two checks:
   - Input 9'h100 (−256) -> `data_o` = 16'hFF00.
   - Drop `en_i` mid-frame for 1 cycle -> `valid_o` = 0 and `frame_cnt_o` = 0 next cycle. A fresh 8 samples (0..7) are then needed before the next frame, which is 0..7.
